// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 encodings,
// FSM state type and the funct3 legality check.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_e;

  // Loads accept all five encodings; stores only accept the signed ones (b/h/w).
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic known;
    known = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
            (f3 == F3_BU) || (f3 == F3_HU);
    return !known || (we && f3[2]);
  endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Byte-lane helper: extracts and sign/zero-extends a load lane from a word,
// and merges right-aligned store data into a word at the addressed lane(s).
// Halfword lane choice uses off_i[1] only, so misaligned halves align down.
module lsu_lane (
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] ext_o,
  output logic [31:0] merge_o
);

  // Load lane extraction with sign extension when funct3[2]=0.
  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    case (off_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i[1:0])
      2'b00:   ext_o = {{24{byte_v[7] & ~funct3_i[2]}}, byte_v};
      2'b01:   ext_o = {{16{half_v[15] & ~funct3_i[2]}}, half_v};
      default: ext_o = word_i;
    endcase
  end

  // Store merge: replace the target byte or half of the captured word.
  always_comb begin
    merge_o = word_i;
    case (funct3_i[1:0])
      2'b00: begin
        case (off_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      2'b01: begin
        if (off_i[1]) merge_o[31:16] = wdata_i;
        else          merge_o[15:0]  = wdata_i;
      end
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between core and word-addressed data memory.
// Sub-word stores use read-modify-write (ACCESS reads, WRITE writes).
// Optional build macro: DMEM_LSU_MISALIGN_CHECK_EN flags misaligned h/w
// accesses as errors; without it they are silently aligned down.
module dmem_lsu
  import dmem_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        misalign;
  logic        req_bad;
  logic        is_sw;
  logic [31:0] ld_ext;
  logic [31:0] st_merge;
  logic [31:0] ld_merge_unused;
  logic [31:0] st_ext_unused;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign is_sw     = we_q && (f3_q == F3_W);

`ifdef DMEM_LSU_MISALIGN_CHECK_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = f3_illegal(req_we, req_funct3) || misalign;

  lsu_lane u_ld_lane (
    .word_i   (mem_rd),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .wdata_i  (wdata_q[15:0]),
    .ext_o    (ld_ext),
    .merge_o  (ld_merge_unused)
  );

  lsu_lane u_st_lane (
    .word_i   (merge_q),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .wdata_i  (wdata_q[15:0]),
    .ext_o    (st_ext_unused),
    .merge_o  (st_merge)
  );

  // Request FSM: latch on accept, perform the access, pulse the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_bad;
            state_q <= req_bad ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!we_q) begin
            rdata_q <= ld_ext;
            state_q <= S_RESP;
          end else if (is_sw) begin
            state_q <= S_RESP;
          end else begin
            merge_q <= mem_rd;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: state_q <= S_RESP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory side decoded from state so reset removes mem_we immediately.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    case (state_q)
      S_ACCESS: begin
        mem_a = {addr_q[31:2], 2'b00};
        if (is_sw) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end
      end
      S_WRITE: begin
        mem_a  = {addr_q[31:2], 2'b00};
        mem_we = 1'b1;
        mem_wd = st_merge;
      end
      default: ;
    endcase
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu with a word-array memory model and a
// behavioural reference of load/store semantics.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_a = '0;
  logic [31:0] tb_d = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (tb_we)       mem[tb_a] <= tb_d;
    else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preset(input int unsigned idx, input logic [31:0] val);
    tb_we = 1'b1;
    tb_a  = idx[5:0];
    tb_d  = val;
    @(negedge clk);
    tb_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Issue one request (called just after a negedge, DUT idle) and check every
  // cycle until the unit is idle again. Expectations come from ISA semantics.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got_rd,
                        output logic got_err);
    logic        legal, mis, err;
    int unsigned lat, we_cyc, idx, bsh, hsh;
    logic [31:0] w, v, exp_rd, new_w, mask;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) &&
            !(we && f3 >= 3'd4);
    mis = 1'b0;
`ifdef DMEM_LSU_MISALIGN_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) mis = 1'b1;
    if (f3 == 3'd2 && addr[1:0] != 2'b00)      mis = 1'b1;
`endif
    err    = !legal || mis;
    idx    = int'(addr[7:2]);
    bsh    = 8 * int'(addr[1:0]);
    hsh    = addr[1] ? 16 : 0;
    w      = ref_mem[idx];
    exp_rd = 32'd0;
    new_w  = w;
    if (err) begin
      lat = 1; we_cyc = 0;
    end else if (!we) begin
      lat = 2; we_cyc = 0;
      if (f3 == 3'd0 || f3 == 3'd4) begin
        v = (w >> bsh) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        v = (w >> hsh) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      exp_rd = v;
    end else if (f3 == 3'd2) begin
      lat = 2; we_cyc = 1; new_w = wd;
    end else begin
      lat = 3; we_cyc = 2;
      if (f3 == 3'd0) begin
        mask  = 32'hFF << bsh;
        new_w = (w & ~mask) | ((wd & 32'hFF) << bsh);
      end else begin
        mask  = 32'hFFFF << hsh;
        new_w = (w & ~mask) | ((wd & 32'hFFFF) << hsh);
      end
    end
    got_rd = 'x; got_err = 1'bx;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int k = 1; k <= int'(lat) + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
      end
      chk("req_ready", {31'd0, req_ready}, {31'd0, k > int'(lat)});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, k == int'(lat)});
      chk("mem_we", {31'd0, mem_we}, {31'd0, k == int'(we_cyc)});
      if (!err && k < int'(lat)) chk("mem_a", mem_a, {24'd0, addr[7:2], 2'b00});
      if (k == int'(we_cyc)) chk("mem_wd", mem_wd, new_w);
      if (k == int'(lat)) begin
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, err});
        got_rd = rsp_rdata; got_err = rsp_err;
      end
      // Requests while busy must be ignored; clear before the unit is idle.
      if (k < int'(lat)) begin
        req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
    end
    ref_mem[idx] = new_w;
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    @(negedge clk);
    for (int unsigned i = 0; i < 64; i++) preset(i, $urandom);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Hand-computed expectations pinning the model.
    preset(4, 32'h8081_8283);
    do_req(1'b0, 3'd0, 32'h11, 32'd0, rd, er); chk("lb_lit", rd, 32'hFFFF_FF82);
    do_req(1'b0, 3'd4, 32'h11, 32'd0, rd, er); chk("lbu_lit", rd, 32'h0000_0082);
    do_req(1'b0, 3'd1, 32'h12, 32'd0, rd, er); chk("lh_lit", rd, 32'hFFFF_8081);
    do_req(1'b0, 3'd5, 32'h12, 32'd0, rd, er); chk("lhu_lit", rd, 32'h0000_8081);
    preset(8, 32'h1122_3344);
    do_req(1'b1, 3'd0, 32'h22, 32'hAA, rd, er); chk("sb_lit", mem[8], 32'h11AA_3344);
    do_req(1'b1, 3'd2, 32'h24, 32'hDEAD_BEEF, rd, er);
    do_req(1'b0, 3'd2, 32'h24, 32'd0, rd, er); chk("lw_lit", rd, 32'hDEAD_BEEF);
    do_req(1'b0, 3'd2, 32'h26, 32'd0, rd, er);
`ifdef DMEM_LSU_MISALIGN_CHECK_EN
    chk("lw_mis_err", {31'd0, er}, 32'd1);
    chk("lw_mis_rd", rd, 32'd0);
`else
    chk("lw_mis_err", {31'd0, er}, 32'd0);
    chk("lw_mis_rd", rd, 32'hDEAD_BEEF);
`endif
    do_req(1'b0, 3'd3, 32'h10, 32'd0, rd, er); chk("ill_ld_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 3'd4, 32'h10, 32'h55, rd, er); chk("ill_st_err", {31'd0, er}, 32'd1);
    chk("ill_st_mem", mem[4], 32'h8081_8283);

    // Reset during WRITE of a halfword store aborts the write and response.
    preset(8, 32'h1122_3344);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h22;
    req_wdata = 32'h5566;
    @(negedge clk);
    req_valid = 1'b0;
    chk("sh_rd_cycle_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("sh_wr_cycle_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("abort_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
    chk("abort_mem", mem[8], 32'h1122_3344);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid3", {31'd0, rsp_valid}, 32'd0);
    do_req(1'b0, 3'd2, 32'h20, 32'd0, rd, er); chk("abort_lw", rd, 32'h1122_3344);

    // Randomized mix of loads, stores, illegal and misaligned accesses.
    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom), 3'($urandom), {24'd0, 8'($urandom)}, $urandom, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that sits between the RISC-V core and the word-addressed data memory. It initiates all data-memory accesses and translates byte, halfword and word loads and stores into word-only memory operations. The memory does combinational reads and registered word writes. Sub-word stores therefore use a read-modify-write sequence. The core issues one request through a valid/ready handshake and receives a single-cycle response pulse.

## Interface
Parameters:
- none. Memory data width is fixed at 32 and byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  high in IDLE only; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- rsp_valid  out  1  one-cycle pulse when the operation completes.
- rsp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; illegal funct3 or misaligned access.
- mem_we  out  1  word write enable to data memory.
- mem_a  out  32  memory byte address, always word-aligned ([1:0] = 00).
- mem_wd  out  32  memory write data.
- mem_rd  in  32  combinational read data for mem_a.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - On accept, latch we, funct3, addr, wdata.
  - Go to RESP with err=1 when funct3 is illegal: 011/110/111, or stores with funct3[2]=1.
  - Also go to RESP with err=1 when the access is misaligned (see Configuration).
  - Otherwise go to ACCESS.
- ACCESS:
  - Drive mem_a = {addr[31:2],2'b00}.
  - Load: extract the lane selected by addr[1:0], extend it, register it into rsp_rdata, then go to RESP.
  - sw: mem_we=1, mem_wd=wdata, then go to RESP.
  - sb/sh: capture mem_rd into a merge register, then go to WRITE.
- WRITE:
  - mem_we=1.
  - mem_wd = captured word with the target lane(s) replaced by wdata[7:0] or wdata[15:0] at byte offset addr[1:0].
  - Then go to RESP.
- RESP: rsp_valid=1, then go to IDLE.
- mem_we is decoded from state and is never high outside ACCESS(sw) or WRITE.
- Lane extraction:
  - lb/lbu take byte addr[1:0].
  - lh/lhu take the half selected by addr[1].
  - Sign extension from bit 7 or 15 applies for funct3[2]=0.
- The unit does not pipeline requests; req_valid is ignored outside IDLE.

## Timing
- Accept occurs at edge 0.
- Load: rsp_valid in cycle 2 (latency 2).
- sw: mem_we in cycle 1, rsp_valid in cycle 2.
- sb/sh: read in cycle 1, mem_we in cycle 2, rsp_valid in cycle 3.
- Error: rsp_valid in cycle 1 and no memory access.
- rsp_valid is high for exactly one cycle; there is no response backpressure.
- A new request may be accepted in the cycle after rsp_valid.
- Reset values:
  - state=IDLE, req_ready=1 (combinational from state).
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_we=0, mem_a=0, mem_wd=0.
- Reset asserted mid-operation aborts immediately: mem_we drops asynchronously and no pending write or response occurs.

## Configuration
- DMEM_LSU_MISALIGN_CHECK_EN defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, gives rsp_err=1 and no memory access.
- Not defined:
  - Misaligned accesses are silently aligned down: halfword uses addr[1] only, word ignores addr[1:0].
  - rsp_err flags only illegal funct3.

## Structure
- Package dmem_lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state typedef.
- Sub-module lsu_lane: combinational lane extract/extend and lane merge, instantiated once for load data and once for store merge.

## Test plan
- Word memory preset 0x8081_8283 at 0x10, lb from 0x11 -> rsp_rdata=0xFFFF_FF82, rsp_valid 2 cycles after accept; lbu -> 0x0000_0082.
- lh from 0x12 -> 0xFFFF_8081; lhu -> 0x0000_8081.
- Word preset 0x1122_3344 at 0x20, sb wdata=0xAA to 0x22 -> a single mem_we in WRITE, word becomes 0x11AA_3344, rsp_valid at cycle 3.
- sw 0xDEAD_BEEF to 0x24 -> mem_we for one cycle in ACCESS, readback lw=0xDEAD_BEEF.
- With the macro defined, lw from 0x26 -> rsp_err=1 at cycle 1 and mem_we never asserted; without the macro -> data from 0x24.
- Assert reset in WRITE of an sh -> mem_we=0 immediately, memory unchanged, no rsp_valid, req_ready=1 after release.
